prefetch_gearbox_32i_16o: RTL and testbench

Single-clock prefetch buffer for the downsizing direction. It accepts wide words with a write-valid/ready handshake and delivers them as two half-width beats in first-word-fall-through style. It pairs with the 16-in/32-out prefetch FIFO used on the packing path: that FIFO packs 16-bit beats into 32-bit words, and this block unpacks 32-bit words back into 16-bit beats for the serial/transceiver-side datapath. Storage is a small register-array FIFO feeding a one-word holding register and an unpacking state machine.

---
 rtl/prefetch_gearbox_32i_16o_if.sv | 24 ++
 rtl/prefetch_gearbox_32i_16o.sv | 123 ++++++++++++
 tb/tb_prefetch_gearbox_32i_16o.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefetch_gearbox_32i_16o_if.sv
// Bus bundle for the 32-in/16-out prefetch gearbox: write handshake, read beat and fill level.
// The master modport is the user side; the slave modport is the gearbox itself.
interface prefetch_gearbox_32i_16o_if #(
   parameter int unsigned DEPTH_WIDTH   = 4,
   parameter int unsigned WR_DATA_WIDTH = 32
);
   logic                         wr_en;
   logic [WR_DATA_WIDTH-1:0]     wr_data;
   logic                         wr_vld;
   logic                         rd_en;
   logic [WR_DATA_WIDTH/2-1:0]   rd_data;
   logic                         rd_vld;
   logic [DEPTH_WIDTH:0]         wr_level;

   modport master (
      output wr_en, wr_data, rd_en,
      input  wr_vld, rd_data, rd_vld, wr_level
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output wr_vld, rd_data, rd_vld, wr_level
   );
endinterface

// File: rtl/prefetch_gearbox_32i_16o.sv
// Downsizing prefetch buffer: register-array FIFO of wide words feeding a holding register
// that emits each word as two half-width beats, first-word-fall-through.
module prefetch_gearbox_32i_16o #(
   parameter int unsigned DEPTH_WIDTH   = 4,
   parameter int unsigned WR_DATA_WIDTH = 32,
   parameter bit          LSB_FIRST     = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   prefetch_gearbox_32i_16o_if.slave  bus
);
   localparam int unsigned Depth = 1 << DEPTH_WIDTH;
   localparam int unsigned RdW   = WR_DATA_WIDTH / 2;

   localparam logic [DEPTH_WIDTH-1:0] PtrOne  = 1;
   localparam logic [DEPTH_WIDTH:0]   LvlOne  = 1;
   localparam logic [DEPTH_WIDTH:0]   LvlZero = '0;
   localparam logic [DEPTH_WIDTH:0]   LvlFull = {1'b1, {DEPTH_WIDTH{1'b0}}};

   typedef enum logic [1:0] {StEmpty, StFirst, StSecond} state_e;

   state_e                   state_q, state_d;
   logic [WR_DATA_WIDTH-1:0] mem_q [Depth];
   logic [DEPTH_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_WIDTH:0]     level_q, level_d;
   logic                     wr_vld_q, wr_vld_d;
   logic [RdW-1:0]           rd_data_q, rd_data_d;
   logic [RdW-1:0]           hold_q, hold_d;

   logic                     wr_fire;
   logic                     pop;
   logic [WR_DATA_WIDTH-1:0] head;
   logic [RdW-1:0]           head_first;
   logic [RdW-1:0]           head_second;

   assign wr_fire     = bus.wr_en & wr_vld_q;
   assign head        = mem_q[rd_ptr_q];
   assign head_first  = LSB_FIRST ? head[RdW-1:0] : head[WR_DATA_WIDTH-1:RdW];
   assign head_second = LSB_FIRST ? head[WR_DATA_WIDTH-1:RdW] : head[RdW-1:0];

   // Unpacking FSM; a pop reloads the holding register from the storage head.
   always_comb begin
      state_d   = state_q;
      rd_data_d = rd_data_q;
      hold_d    = hold_q;
      pop       = 1'b0;
      unique case (state_q)
         StEmpty: begin
            pop = (level_q != LvlZero);
         end
         StFirst: begin
            if (bus.rd_en) begin
               rd_data_d = hold_q;
               state_d   = StSecond;
            end
         end
         StSecond: begin
            if (bus.rd_en) begin
               if (level_q != LvlZero) begin
                  pop = 1'b1;
               end else begin
                  state_d = StEmpty;
               end
            end
         end
         default: begin
            state_d = StEmpty;
         end
      endcase
      if (pop) begin
         rd_data_d = head_first;
         hold_d    = head_second;
         state_d   = StFirst;
      end
   end

   always_comb begin
      wr_ptr_d = wr_fire ? wr_ptr_q + PtrOne : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
      level_d  = level_q;
      if (wr_fire && !pop) begin
         level_d = level_q + LvlOne;
      end else if (!wr_fire && pop) begin
         level_d = level_q - LvlOne;
      end
      // Ready looks only at storage occupancy, so a full store never takes a write.
      wr_vld_d = (level_d != LvlFull);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StEmpty;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         wr_vld_q  <= 1'b0;
         rd_data_q <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         wr_vld_q  <= wr_vld_d;
         rd_data_q <= rd_data_d;
         hold_q    <= hold_d;
      end
   end

   // Storage array needs no reset: pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q] <= bus.wr_data;
      end
   end

   assign bus.wr_vld   = wr_vld_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_vld   = (state_q != StEmpty);
   assign bus.wr_level = level_q;

endmodule

// File: tb/tb_prefetch_gearbox_32i_16o.sv
// Self-checking bench: two gearbox instances (16-deep LSB-first, 4-deep MSB-first) share stimulus
// and are compared every cycle against a word-queue / beat-queue reference model.
module tb_prefetch_gearbox_32i_16o;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] wr_data = '0;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   prefetch_gearbox_32i_16o_if #(.DEPTH_WIDTH(4), .WR_DATA_WIDTH(32)) if_a ();
   prefetch_gearbox_32i_16o_if #(.DEPTH_WIDTH(2), .WR_DATA_WIDTH(32)) if_b ();

   assign if_a.wr_en   = wr_en;
   assign if_a.wr_data = wr_data;
   assign if_a.rd_en   = rd_en;
   assign if_b.wr_en   = wr_en;
   assign if_b.wr_data = wr_data;
   assign if_b.rd_en   = rd_en;

   prefetch_gearbox_32i_16o #(
      .DEPTH_WIDTH  (4),
      .WR_DATA_WIDTH(32),
      .LSB_FIRST    (1'b1)
   ) u_dut_a (
      .clk(clk),
      .rst(rst),
      .bus(if_a)
   );

   prefetch_gearbox_32i_16o #(
      .DEPTH_WIDTH  (2),
      .WR_DATA_WIDTH(32),
      .LSB_FIRST    (1'b0)
   ) u_dut_b (
      .clk(clk),
      .rst(rst),
      .bus(if_b)
   );

   logic [15:0] act_rd_data [2];
   logic        act_rd_vld  [2];
   logic        act_wr_vld  [2];
   int          act_level   [2];

   always_comb begin
      act_rd_data[0] = if_a.rd_data;
      act_rd_data[1] = if_b.rd_data;
      act_rd_vld[0]  = if_a.rd_vld;
      act_rd_vld[1]  = if_b.rd_vld;
      act_wr_vld[0]  = if_a.wr_vld;
      act_wr_vld[1]  = if_b.wr_vld;
      act_level[0]   = int'(if_a.wr_level);
      act_level[1]   = int'(if_b.wr_level);
   end

   // Reference model: a queue of stored words and a queue of pending beats per instance.
   int          depth [2] = '{16, 4};
   bit          lsb   [2] = '{1'b1, 1'b0};
   logic [31:0] st_mem  [2][64];
   int          st_head [2];
   int          st_cnt  [2];
   logic [15:0] hb      [2][2];
   int          hb_cnt  [2];
   logic        m_wr_vld[2];
   int          acc_cnt [2] = '{0, 0};

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         st_head[i]  = 0;
         st_cnt[i]   = 0;
         hb_cnt[i]   = 0;
         m_wr_vld[i] = 1'b0;
      end
   endfunction

   function automatic void model_step();
      logic [31:0] w;
      bit          wf;
      for (int i = 0; i < 2; i++) begin
         wf = wr_en && m_wr_vld[i];
         if (rd_en && hb_cnt[i] > 0) begin
            hb[i][0] = hb[i][1];
            hb_cnt[i]--;
         end
         if (hb_cnt[i] == 0 && st_cnt[i] > 0) begin
            w          = st_mem[i][st_head[i]];
            st_head[i] = (st_head[i] + 1) % 64;
            st_cnt[i]--;
            hb[i][0]   = lsb[i] ? w[15:0] : w[31:16];
            hb[i][1]   = lsb[i] ? w[31:16] : w[15:0];
            hb_cnt[i]  = 2;
         end
         if (wf) begin
            st_mem[i][(st_head[i] + st_cnt[i]) % 64] = wr_data;
            st_cnt[i]++;
            acc_cnt[i]++;
         end
         m_wr_vld[i] = (st_cnt[i] < depth[i]);
      end
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int i = 0; i < 2; i++) begin
               chk($sformatf("cyc_rd_vld[%0d]", i), 32'(act_rd_vld[i]), 32'(hb_cnt[i] > 0));
               chk($sformatf("cyc_wr_vld[%0d]", i), 32'(act_wr_vld[i]), 32'(m_wr_vld[i]));
               chk($sformatf("cyc_level[%0d]", i), act_level[i], st_cnt[i]);
               if (hb_cnt[i] > 0) begin
                  chk($sformatf("cyc_rd_data[%0d]", i), 32'(act_rd_data[i]), 32'(hb[i][0]));
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int beats;
      int a0;

      repeat (3) step();
      chk("rst_rd_vld", 32'(act_rd_vld[0]), 0);
      chk("rst_rd_data", 32'(act_rd_data[0]), 0);
      chk("rst_level", act_level[0], 0);
      chk("rst_wr_vld", 32'(act_wr_vld[0]), 0);
      rst = 1'b0;
      chk("rel_wr_vld_pre", 32'(act_wr_vld[0]), 0);
      step();
      chk("rel_wr_vld_post", 32'(act_wr_vld[0]), 1);

      // Single word, both half orders
      wr_en = 1'b1;
      wr_data = 32'hBEEF_1234;
      step();
      wr_en = 1'b0;
      chk("single_lat_vld", 32'(act_rd_vld[0]), 0);
      step();
      chk("single_vld", 32'(act_rd_vld[0]), 1);
      chk("single_a_first", 32'(act_rd_data[0]), 32'h1234);
      chk("single_b_first", 32'(act_rd_data[1]), 32'hBEEF);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("single_a_second", 32'(act_rd_data[0]), 32'hBEEF);
      chk("single_b_second", 32'(act_rd_data[1]), 32'h1234);
      chk("single_vld2", 32'(act_rd_vld[0]), 1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("single_a_empty", 32'(act_rd_vld[0]), 0);
      chk("single_b_empty", 32'(act_rd_vld[1]), 0);

      // Streaming: one word every two clocks, rd_en held
      rd_en = 1'b1;
      for (int c = 0; c < 18; c++) begin
         wr_en = (c % 2 == 0) && (c < 16);
         wr_data = {16'(c + 1), 16'(c)};
         step();
         if (c >= 1 && c <= 16) begin
            chk("stream_vld", 32'(act_rd_vld[0]), 1);
            chk("stream_data", 32'(act_rd_data[0]), 32'(16'(c - 1)));
            chk("stream_level", 32'(act_level[0] <= 1), 1);
         end
      end
      wr_en = 1'b0;
      rd_en = 1'b0;

      // Asynchronous reset mid-cycle with data in flight
      wr_en = 1'b1;
      wr_data = 32'h5A5A_C3C3;
      step();
      wr_en = 1'b0;
      step();
      chk("pre_rst_vld", 32'(act_rd_vld[0]), 1);
      chk("pre_rst_data", 32'(act_rd_data[0]), 32'hC3C3);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_rd_vld_a", 32'(act_rd_vld[0]), 0);
      chk("arst_rd_vld_b", 32'(act_rd_vld[1]), 0);
      chk("arst_rd_data_a", 32'(act_rd_data[0]), 0);
      chk("arst_rd_data_b", 32'(act_rd_data[1]), 0);
      chk("arst_level", act_level[0], 0);
      chk("arst_wr_vld", 32'(act_wr_vld[0]), 0);
      step();
      step();
      rst = 1'b0;
      chk("arel_wr_vld_pre", 32'(act_wr_vld[0]), 0);
      step();
      chk("arel_wr_vld_post", 32'(act_wr_vld[0]), 1);

      // Fill with no reads
      a0 = acc_cnt[0];
      wr_en = 1'b1;
      for (int c = 0; c < 20; c++) begin
         wr_data = $urandom;
         step();
      end
      wr_en = 1'b0;
      chk("fill_model_accepted", acc_cnt[0] - a0, 17);
      chk("fill_level", act_level[0], 16);
      chk("fill_wr_vld", 32'(act_wr_vld[0]), 0);
      chk("fill_level_b", act_level[1], 4);

      // Drain from full
      beats = 0;
      if (act_rd_vld[0]) beats++;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("drain1_level", act_level[0], 16);
      chk("drain1_wr_vld", 32'(act_wr_vld[0]), 0);
      chk("drain1_vld", 32'(act_rd_vld[0]), 1);
      if (act_rd_vld[0]) beats++;
      rd_en = 1'b1;
      step();
      chk("drain2_vld", 32'(act_rd_vld[0]), 1);
      chk("drain2_level", act_level[0], 15);
      chk("drain2_wr_vld", 32'(act_wr_vld[0]), 1);
      for (int c = 0; c < 100 && act_rd_vld[0]; c++) begin
         beats++;
         step();
      end
      rd_en = 1'b0;
      chk("drain_beats", beats, 34);
      chk("drain_empty", 32'(act_rd_vld[0]), 0);

      // Random traffic; the 4-deep instance wraps its pointers many times
      a0 = acc_cnt[1];
      for (int c = 0; c < 20000 && (acc_cnt[1] - a0) < 1000; c++) begin
         wr_en = ($urandom_range(0, 3) != 0);
         wr_data = $urandom;
         rd_en = ($urandom_range(0, 2) != 0);
         step();
      end
      chk("rand_writes_done", 32'((acc_cnt[1] - a0) >= 1000), 1);
      wr_en = 1'b0;
      rd_en = 1'b1;
      repeat (60) step();
      rd_en = 1'b0;
      chk("final_empty_a", 32'(act_rd_vld[0]), 0);
      chk("final_empty_b", 32'(act_rd_vld[1]), 0);
      chk("final_level_a", act_level[0], 0);
      chk("final_level_b", act_level[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
